// File: rtl/spw_flow_pkg.sv
// Shared SpaceWire flow-control constants and state encodings.
// The receive-side FCT credit manager and the transmit-side FCT counter both import this package.
package spw_flow_pkg;

    localparam int FCT_CHUNK  = 8;
    localparam int MAX_CREDIT = 56;
    localparam int CREDIT_W   = 6;

    // Receive side: FCT request handshake towards the tx FSM.
    typedef enum logic [1:0] {
        RX_FCT_IDLE   = 2'd0,
        RX_FCT_REQ    = 2'd1,
        RX_FCT_SETTLE = 2'd2
    } rx_fct_state_e;

    // Transmit side: FCT send path as seen from the tx FSM.
    typedef enum logic [1:0] {
        TX_FCT_WAIT = 2'd0,
        TX_FCT_SEND = 2'd1,
        TX_FCT_DONE = 2'd2
    } tx_fct_state_e;

endpackage

// File: rtl/rx_fct_credit.sv
// Receiver-side SpaceWire flow-control credit manager: tracks credit the far end holds,
// requests FCTs while the rx FIFO can absorb another chunk, flags credit underflow.
module rx_fct_credit
    import spw_flow_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int MAX_CRED   = spw_flow_pkg::MAX_CREDIT,
    parameter int CHUNK      = spw_flow_pkg::FCT_CHUNK,
    localparam int FREE_W    = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                pclk_rx,
    input  logic                reset_rx,
    input  logic                enable_rx,
    input  logic                gotnchar_rx,
    input  logic [FREE_W-1:0]   fifo_free,
    input  logic                fct_ack,
    output logic                fct_req,
    output logic [CREDIT_W-1:0] credit_out,
    output logic                credit_error
);

    // One extra bit so credit + chunk can never wrap during the space check.
    localparam int CMP_W = FREE_W + 1;

    rx_fct_state_e         state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic                  error_q, error_d;

    logic                  elig;
    logic                  ack_ok;
    logic [CMP_W-1:0]      credit_ext;
    logic [CMP_W-1:0]      grant_sum;

    always_comb begin
        credit_ext = CMP_W'(credit_q);
        grant_sum  = credit_ext + CMP_W'(CHUNK);
        elig       = (credit_q <= CREDIT_W'(MAX_CRED - CHUNK))
                  && (grant_sum <= CMP_W'(fifo_free));
        ack_ok     = (state_q == RX_FCT_REQ) && fct_ack;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_FCT_IDLE:   if (elig) state_d = RX_FCT_REQ;
            // The request is never withdrawn once raised, whatever happens to elig.
            RX_FCT_REQ:    if (fct_ack) state_d = RX_FCT_SETTLE;
            RX_FCT_SETTLE: state_d = RX_FCT_IDLE;
            default:       state_d = RX_FCT_IDLE;
        endcase
        if (!enable_rx) state_d = RX_FCT_IDLE;
    end

    always_comb begin
        credit_d = credit_q;
        error_d  = error_q;
        case ({ack_ok, gotnchar_rx})
            2'b11:   credit_d = credit_q + CREDIT_W'(CHUNK - 1);
            2'b10:   credit_d = credit_q + CREDIT_W'(CHUNK);
            2'b01: begin
                // An N-char with nothing outstanding means the far end overran its grant.
                if (credit_q != '0) credit_d = credit_q - CREDIT_W'(1);
                else                error_d  = 1'b1;
            end
            default: credit_d = credit_q;
        endcase
        if (!enable_rx) begin
            credit_d = '0;
            error_d  = 1'b0;
        end
    end

    always_ff @(posedge pclk_rx or posedge reset_rx) begin
        if (reset_rx) begin
            state_q  <= RX_FCT_IDLE;
            credit_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            error_q  <= error_d;
        end
    end

    assign fct_req      = (state_q == RX_FCT_REQ);
    assign credit_out   = credit_q;
    assign credit_error = error_q;

endmodule

// File: tb/tb_rx_fct_credit.sv
// Directed bench for rx_fct_credit: credit ramp, FIFO-space gating, underflow error,
// simultaneous ack/N-char, stalled ack and asynchronous reset mid-request.
module tb_rx_fct_credit;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       nchar;
    logic [6:0] free;
    logic       ack;
    logic       fct_req;
    logic [5:0] credit_out;
    logic       credit_error;

    int passed = 0;
    int total  = 0;

    rx_fct_credit dut (
        .pclk_rx      (clk),
        .reset_rx     (rst),
        .enable_rx    (en),
        .gotnchar_rx  (nchar),
        .fifo_free    (free),
        .fct_ack      (ack),
        .fct_req      (fct_req),
        .credit_out   (credit_out),
        .credit_error (credit_error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; nchar = 1'b0; free = 7'd0; ack = 1'b0;
        step(); step();
        chk("rst_req", 32'(fct_req), 0);
        chk("rst_credit", 32'(credit_out), 0);
        chk("rst_err", 32'(credit_error), 0);
        rst = 1'b0;
        step();
        chk("en_low_req", 32'(fct_req), 0);

        // Ramp: seven grants of 8 up to 56, the eighth is withheld.
        en = 1'b1; free = 7'd64;
        step();
        chk("ramp_first_req", 32'(fct_req), 1);
        chk("ramp_first_credit", 32'(credit_out), 0);
        for (int i = 0; i < 7; i++) begin
            ack = 1'b1; step(); ack = 1'b0;
            chk("ramp_credit", 32'(credit_out), 32'(8 * (i + 1)));
            chk("ramp_settle_req", 32'(fct_req), 0);
            step();
            chk("ramp_idle_req", 32'(fct_req), 0);
            step();
            chk("ramp_next_req", 32'(fct_req), (i < 6) ? 32'd1 : 32'd0);
        end
        step(); step();
        chk("ramp_no_8th_req", 32'(fct_req), 0);
        ack = 1'b1; step(); ack = 1'b0;
        chk("stray_ack_credit", 32'(credit_out), 56);
        en = 1'b0; step();
        chk("en_clear_credit", 32'(credit_out), 0);
        chk("en_clear_req", 32'(fct_req), 0);

        // FIFO space of 20 allows two grants; 24 allows a third.
        en = 1'b1; free = 7'd20;
        step();
        chk("space_req1", 32'(fct_req), 1);
        ack = 1'b1; step(); ack = 1'b0;
        step(); step();
        chk("space_req2", 32'(fct_req), 1);
        ack = 1'b1; step(); ack = 1'b0;
        chk("space_credit16", 32'(credit_out), 16);
        step(); step(); step(); step();
        chk("space_withheld", 32'(fct_req), 0);
        free = 7'd24;
        step();
        chk("space_req3", 32'(fct_req), 1);
        ack = 1'b1; step(); ack = 1'b0;
        chk("space_credit24", 32'(credit_out), 24);

        // Drain 8 credits, then one N-char too many.
        en = 1'b0; step();
        en = 1'b1; free = 7'd8;
        step();
        ack = 1'b1; step(); ack = 1'b0;
        free = 7'd0;
        step();
        chk("drain_start_credit", 32'(credit_out), 8);
        nchar = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("drain_credit0", 32'(credit_out), 0);
        chk("drain_no_err", 32'(credit_error), 0);
        step(); nchar = 1'b0;
        chk("underflow_err", 32'(credit_error), 1);
        chk("underflow_credit", 32'(credit_out), 0);
        free = 7'd64;
        step(); step(); step();
        chk("err_sticky", 32'(credit_error), 1);
        chk("err_still_requests", 32'(fct_req), 1);
        en = 1'b0; step();
        chk("err_cleared", 32'(credit_error), 0);

        // Credit 3 in REQ, N-char and ack together give 10; SETTLE lasts one cycle.
        en = 1'b1;
        step();
        ack = 1'b1; step(); ack = 1'b0;
        nchar = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("combo_pre_credit", 32'(credit_out), 3);
        chk("combo_pre_req", 32'(fct_req), 1);
        ack = 1'b1; step(); ack = 1'b0; nchar = 1'b0;
        chk("combo_credit10", 32'(credit_out), 10);
        chk("combo_settle_req", 32'(fct_req), 0);
        step();
        chk("combo_idle_req", 32'(fct_req), 0);
        step();
        chk("combo_rereq", 32'(fct_req), 1);

        // Stalled ack while FIFO space vanishes: request held.
        free = 7'd0;
        for (int i = 0; i < 10; i++) step();
        chk("stall_req_held", 32'(fct_req), 1);
        chk("stall_credit", 32'(credit_out), 10);
        ack = 1'b1; step(); ack = 1'b0;
        chk("stall_ack_credit", 32'(credit_out), 18);

        // Zero credit plus accepted ack with an N-char is legal: credit 7.
        en = 1'b0; step();
        en = 1'b1; free = 7'd64;
        step();
        nchar = 1'b1; ack = 1'b1; step(); nchar = 1'b0; ack = 1'b0;
        chk("zero_combo_credit", 32'(credit_out), 7);
        chk("zero_combo_err", 32'(credit_error), 0);

        // Asynchronous reset mid-request, then an ack that must be ignored.
        step(); step();
        chk("arst_pre_req", 32'(fct_req), 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_req", 32'(fct_req), 0);
        chk("arst_credit", 32'(credit_out), 0);
        rst = 1'b0; ack = 1'b1;
        step(); ack = 1'b0;
        chk("arst_ack_ignored", 32'(credit_out), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
